pwm_capture: RTL and testbench

Measures an incoming PWM signal and recovers a 10-bit command value plus the period. It is the inverse of the motor-drive PWM generator: the generator's `Offset` is removed and the high time is clamped. Typical uses are decoding a throttle or hall-derived PWM line, and loop-back checking of the drive output in the motor path.

---
 rtl/pwm_capture.sv | 167 ++++++++++++++++
 tb/tb_pwm_capture.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and recovers a 10-bit
// command (high ticks minus Offset, clamped to 0..1023) and the rise-to-rise
// period in ticks. A tick is Prescale CLOCK_50 cycles.
// Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
// Output protocol: Valid is a one-cycle strobe with no back-pressure; Duty,
// Period and Timeout are valid in the cycle Valid is high and hold until the
// next strobe. fsm_state exposes the measurement state for observation.
module pwm_capture #(
  parameter int Prescale     = 128,
  parameter int Offset       = 250,
  parameter int TimeoutTicks = 2048,
  parameter int FilterLen    = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        PWMin,
  output logic [9:0]  Duty,
  output logic [15:0] Period,
  output logic        Valid,
  output logic        Timeout,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam int PW = (Prescale > 1) ? $clog2(Prescale) : 1;

  logic        s1;
  logic        s;
  logic        lvl;
  logic        prev;
  logic        rise;
  logic        fall;
  logic [PW-1:0] psc;
  logic        tick;
  logic [15:0] hcnt;
  logic [15:0] pcnt;
  logic [15:0] hcap;
  logic [1:0]  state;
  logic        timeout_hit;
  logic [16:0] diff;
  logic [9:0]  duty_next;

  // Two-flop synchronizer for the asynchronous input
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= PWMin;
      s  <= s1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FW = $clog2(FilterLen + 1);
  logic          filt;
  logic [FW-1:0] fcnt;

  // Filtered level follows s only after FilterLen consecutive differing samples
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (s == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FilterLen - 1)) begin
      filt <= s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = s;
`endif

  // One-cycle delayed copy of the level for edge detection
  always_ff @(posedge CLOCK_50) begin
    if (RESET) prev <= 1'b0;
    else       prev <= lvl;
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

  // Tick fires while the prescaler sits at its last count
  assign tick = (psc == PW'(Prescale - 1));

  // Prescaler, re-phased on every rising edge so ticks align to the pulse
  always_ff @(posedge CLOCK_50) begin
    if (RESET || rise) psc <= '0;
    else if (tick)     psc <= '0;
    else               psc <= psc + 1'b1;
  end

  // Saturating high-time and period tick counters, restarted on rise
  always_ff @(posedge CLOCK_50) begin
    if (RESET || rise) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (tick) begin
      if (pcnt != 16'hFFFF) pcnt <= pcnt + 16'd1;
      if ((state == HIGH) && (hcnt != 16'hFFFF)) hcnt <= hcnt + 16'd1;
    end
  end

  // The period counter is about to reach the limit on this tick
  assign timeout_hit = tick && (pcnt == 16'(TimeoutTicks - 1)) && (state != IDLE);

  // Duty = hcap - Offset, evaluated as a signed 17-bit value then clamped
  assign diff = {1'b0, hcap} - 17'(Offset);

  // Clamp the subtraction into the 10-bit command range
  always_comb begin
    duty_next = 10'd0;
    if (diff[16])               duty_next = 10'd0;
    else if (diff[15:10] != '0) duty_next = 10'd1023;
    else                        duty_next = diff[9:0];
  end

  // Measurement FSM and registered outputs; rise in LOW beats a timeout tick
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state   <= IDLE;
      hcap    <= '0;
      Duty    <= '0;
      Period  <= '0;
      Valid   <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if ((state == LOW) && rise) begin
        Duty    <= duty_next;
        Period  <= pcnt;
        Valid   <= 1'b1;
        Timeout <= 1'b0;
        state   <= HIGH;
      end else if (timeout_hit) begin
        Duty    <= lvl ? 10'd1023 : 10'd0;
        Period  <= '0;
        Valid   <= 1'b1;
        Timeout <= 1'b1;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: if (rise) state <= HIGH;
          HIGH: begin
            if (fall) begin
              hcap  <= hcnt;
              state <= LOW;
            end
          end
          LOW:     state <= LOW;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM stimulus with a scoreboard of expected
// {Timeout, Duty, Period} results, compared whenever Valid strobes.
// Scaled parameters keep the run short: Prescale=2, Offset=10, Timeout=1600.
module tb_pwm_capture;

  localparam int PS  = 2;
  localparam int OFF = 10;
  localparam int TT  = 1600;
  localparam int FL  = 4;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int ZH = 5;
`else
  localparam int ZH = 1;
`endif

  logic        clk;
  logic        rst;
  logic        pwm;
  logic [9:0]  duty;
  logic [15:0] period;
  logic        valid;
  logic        tout;
  logic [1:0]  fsm_state;

  logic [26:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  logic        armed;
  int          ph;
  int          pl;
  logic        valid_d;
  logic [9:0]  last_duty;

  pwm_capture #(
    .Prescale(PS), .Offset(OFF), .TimeoutTicks(TT), .FilterLen(FL)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .PWMin(pwm),
    .Duty(duty), .Period(period), .Valid(valid), .Timeout(tout),
    .fsm_state(fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] clamp10(input int v);
    if (v < 0)    return 10'd0;
    if (v > 1023) return 10'd1023;
    return v[9:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard pushes
  task automatic push_period(input int h, input int l);
    exp_q.push_back({1'b0, clamp10(((h - 1) / PS) - OFF), 16'((h + l - 1) / PS)});
  endtask

  // Driver tasks (inputs change on the falling edge)
  task automatic drive(input logic v, input int n);
    pwm = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_period(input int h, input int l);
    if (armed) push_period(ph, pl);
    ph = h; pl = l; armed = 1'b1;
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic pwm_glitch(input int a, input int g, input int b, input int l);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    if (armed) push_period(ph, pl);
    ph = a + g + b; pl = l; armed = 1'b1;
    drive(1'b1, a);
    drive(1'b0, g);
    drive(1'b1, b);
    drive(1'b0, l);
`else
    pwm_period(a, g);
    pwm_period(b, l);
`endif
  endtask

  task automatic hold(input logic v, input int n);
    if (v) begin
      if (armed) push_period(ph, pl);
      exp_q.push_back({1'b1, 10'd1023, 16'd0});
      armed = 1'b0;
    end else if (armed) begin
      exp_q.push_back({1'b1, 10'd0, 16'd0});
      armed = 1'b0;
    end
    drive(v, n);
  endtask

  // Scoreboard compare on each Valid strobe
  always @(negedge clk) begin
    if (!rst && valid) begin
      check("valid_gap", {31'd0, valid_d}, 32'd0);
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed valid with empty queue, duty %0d period %0d", duty, period);
      end
      if (exp_q.size() != 0) begin
        logic [26:0] e;
        e = exp_q.pop_front();
        last_duty = e[25:16];
        check("sb_timeout", {31'd0, tout}, {31'd0, e[26]});
        check("sb_duty", {22'd0, duty}, {22'd0, e[25:16]});
        check("sb_period", {16'd0, period}, {16'd0, e[15:0]});
      end
    end
    valid_d = rst ? 1'b0 : valid;
  end

  // Directed stimulus
  initial begin
    n_checks = 0; n_fail = 0; armed = 1'b0; ph = 0; pl = 0;
    valid_d = 1'b0; last_duty = 10'd0;
    rst = 1'b1; pwm = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_duty", {22'd0, duty}, 32'd0);
    check("rst_period", {16'd0, period}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_timeout", {31'd0, tout}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 10);

    // Reset in the middle of a high phase discards the measurement
    pwm_period(41, 60);
    push_period(41, 60);
    armed = 1'b0;
    drive(1'b1, 20);
    rst = 1'b1;
    drive(1'b1, 2);
    check("midrst_duty", {22'd0, duty}, 32'd0);
    check("midrst_period", {16'd0, period}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_state", {30'd0, fsm_state}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 10);
    pwm_period(51, 50);
    pwm_period(71, 30);
    pwm_period(31, 70);

    // Clamping and zero-high boundary
    pwm_period(15, 40);
    pwm_period(ZH, 51);
    pwm_period(2801, 200);

    // Nominal decode: 160 high ticks, 531 period ticks
    pwm_period(321, 742);
    pwm_period(321, 742);
    pwm_period(321, 742);

    // Short low glitch inside the high phase
    pwm_glitch(101, 2, 101, 60);
    pwm_period(81, 40);

    // Input held low: timeout, then two rises clear it and publish
    hold(1'b0, 2 * TT + 200);
    check("tlow_flag", {31'd0, tout}, 32'd1);
    check("tlow_state", {30'd0, fsm_state}, 32'd0);
    pwm_period(41, 60);
    check("first_rise_keeps_flag", {31'd0, tout}, 32'd1);
    pwm_period(61, 40);
    check("flag_cleared", {31'd0, tout}, 32'd0);

    // Input held high: timeout with full-scale duty
    hold(1'b1, 2 * TT + 200);
    hold(1'b0, 20);
    check("thigh_flag", {31'd0, tout}, 32'd1);

    // Closing measurement, published by one final rise
    pwm_period(31, 30);
    pwm_period(45, 30);
    armed = 1'b0;

    // Bounded drain of the scoreboard
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    repeat (20) @(negedge clk);
    check("duty_hold", {22'd0, duty}, {22'd0, last_duty});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
